// File: rtl/fetch_stage_pkg.sv
// Shared pipeline package: fetch constants, fetch FSM state encoding and a
// small address helper. Also imported by the controller, which decodes
// opcode 6'h3F as halt.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings (hazard unit, EX, ROM,
// IF/ID consumer and UI statistics).
//   stall, redirect, redirect_pc : control from the bubbler and EX
//   imem_addr / imem_data        : instruction ROM port
//   id_instr, id_pc4, id_valid   : IF/ID pipeline register
//   pc, cc, fetch_count, halted, misaligned, state : status and debug
// Control semantics: redirect and stall are level signals sampled on every
// rising clock edge with no acknowledge; redirect beats stall, and a stall
// seen during the FLUSH cycle after a redirect is ignored.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_data;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc4;
  logic         id_valid;
  logic [31:0]  pc;
  logic [15:0]  cc;
  logic [15:0]  fetch_count;
  logic         halted;
  logic         misaligned;
  fetch_state_t state;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, id_instr, id_pc4, id_valid, pc, cc, fetch_count,
           halted, misaligned, state
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, id_instr, id_pc4, id_valid, pc, cc, fetch_count,
           halted, misaligned, state
  );
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Up-counter with asynchronous active-high reset.
//   clock, reset : clock and async reset (count -> 0)
//   en           : count this cycle
//   count        : current value; holds at all-ones when SATURATE=1,
//                  otherwise wraps to zero
module fetch_stage_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max;
  assign at_max = &count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && !(SATURATE && at_max)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID register. Honours load-use stalls and EX redirects, stops
// on the halt word, and keeps a saturating cycle counter plus a wrapping
// fetch counter for the UI.
//   clock, reset : pipeline clock, async active-high reset
//   bus          : fetch_stage_if.master (controls, ROM port, IF/ID, status)
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  fetch_state_t state, state_next;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        fetch_en;
  logic        bubble;
  logic        halt_hit;

  assign pc_plus4 = pc_q + 32'd4;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next-state logic; a redirect pre-empts everything including HALT entry.
  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_HALT:  state_next = ST_HALT;
        ST_FLUSH: state_next = halt_hit ? ST_HALT : ST_RUN;
        default:  state_next = halt_hit ? ST_HALT : ST_RUN;
      endcase
    end
  end

  // Output/control decode. FLUSH fetches even under stall so stale bubbler
  // requests cannot hold the redirected fetch.
  always_comb begin
    fetch_en = 1'b0;
    bubble   = 1'b0;
    halt_hit = 1'b0;
    if (bus.redirect || state == ST_HALT) begin
      bubble = 1'b1;
    end else if (!bus.stall || state == ST_FLUSH) begin
      fetch_en = 1'b1;
      halt_hit = (bus.imem_data == HALT_WORD);
    end
  end

  // PC: the halt word is latched into IF/ID but the PC stays on it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect) begin
      pc_q <= word_align(bus.redirect_pc);
    end else if (fetch_en && !halt_hit) begin
      pc_q <= pc_plus4;
    end
  end

  // IF/ID register; id_pc4 is only meaningful while id_valid is set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.id_instr <= NOP_WORD;
      bus.id_pc4   <= 32'h0;
      bus.id_valid <= 1'b0;
    end else if (bubble) begin
      bus.id_instr <= NOP_WORD;
      bus.id_valid <= 1'b0;
    end else if (fetch_en) begin
      bus.id_instr <= bus.imem_data;
      bus.id_pc4   <= pc_plus4;
      bus.id_valid <= 1'b1;
    end
  end

  // Sticky flag: any redirect target that was not word aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.misaligned <= 1'b0;
    end else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
      bus.misaligned <= 1'b1;
    end
  end

  fetch_stage_sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_cc (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .count (bus.cc)
  );

  fetch_stage_sat_counter #(.WIDTH(16), .SATURATE(1'b0)) u_fetch_count (
    .clock (clock),
    .reset (reset),
    .en    (fetch_en),
    .count (bus.fetch_count)
  );

  assign bus.pc        = pc_q;
  assign bus.imem_addr = pc_q;
  assign bus.halted    = (state == ST_HALT);
  assign bus.state     = state;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  fetch_stage_if bus();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- ROM model ----------------
  logic [31:0] rom_mem [0:255];

  function automatic logic [31:0] rom_hash(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    w[31] = 1'b0;  // never produces opcode 6'h3F
    return w;
  endfunction

  function automatic logic [31:0] rom_read(input logic [31:0] a);
    if (a < 32'd1024) return rom_mem[a[9:2]];
    return rom_hash(a);
  endfunction

  // ROM reads on the falling edge
  always @(negedge clock) bus.imem_data = rom_read(bus.imem_addr);

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted, m_flush, m_mis;
  int          m_cycles, m_fetches;
  int          total, bad;

  function automatic logic [15:0] exp_cc();
    return (m_cycles > 65535) ? 16'hFFFF : m_cycles[15:0];
  endfunction

  function automatic logic [15:0] exp_fc();
    return m_fetches[15:0];
  endfunction

  function automatic fetch_state_t exp_state();
    if (m_halted) return ST_HALT;
    if (m_flush)  return ST_FLUSH;
    return ST_RUN;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_WORD; m_pc4 = 32'h0; m_valid = 1'b0;
    m_halted = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
    m_cycles = 0; m_fetches = 0;
  endtask

  // One rising edge as described by the fetch rules.
  task automatic model_edge();
    logic [31:0] w;
    m_cycles++;
    if (bus.redirect) begin
      m_pc = {bus.redirect_pc[31:2], 2'b00};
      m_instr = NOP_WORD; m_valid = 1'b0;
      m_halted = 1'b0; m_flush = 1'b1;
      if (bus.redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (m_halted) begin
      m_instr = NOP_WORD; m_valid = 1'b0;
    end else if (bus.stall && !m_flush) begin
      // hold everything
    end else begin
      w = rom_read(m_pc);
      m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_fetches++;
      m_flush = 1'b0;
      if (w == HALT_WORD) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic rom_init();
    for (int i = 0; i < 256; i++) rom_mem[i] = rom_hash(32'(i * 4));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    repeat (3) cycle();
    @(posedge clock); #2;
    reset = 1'b1;  // asserted between edges
    model_reset();
    #1;
    total++; if (bus.pc !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RESET_PC); end
    total++; if (bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_imem_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    total++; if (bus.id_instr !== NOP_WORD || bus.id_valid !== 1'b0 || bus.id_pc4 !== 32'h0) begin bad++; $display("FAIL reset_ifid got=%h/%h/%b exp=%h/0/0", bus.id_instr, bus.id_pc4, bus.id_valid, NOP_WORD); end
    total++; if (bus.cc !== 16'h0 || bus.fetch_count !== 16'h0) begin bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", bus.cc, bus.fetch_count); end
    total++; if (bus.halted !== 1'b0 || bus.misaligned !== 1'b0 || bus.state !== ST_RUN) begin bad++; $display("FAIL reset_flags got=%b/%b/%0d exp=0/0/RUN", bus.halted, bus.misaligned, bus.state); end
  endtask

  task automatic test_basic_fetch();
    rom_mem[0] = 32'h2008_0001;
    rom_mem[1] = 32'h2009_0002;
    do_reset();
    cycle();
    total++; if (bus.id_instr !== 32'h2008_0001 || bus.id_pc4 !== 32'h4 || bus.id_valid !== 1'b1) begin bad++; $display("FAIL basic_edge1 got=%h/%h/%b exp=20080001/4/1", bus.id_instr, bus.id_pc4, bus.id_valid); end
    cycle();
    total++; if (bus.pc !== 32'h8 || bus.id_instr !== 32'h2009_0002) begin bad++; $display("FAIL basic_edge2 got pc=%h instr=%h exp pc=8 instr=20090002", bus.pc, bus.id_instr); end
    total++; if (bus.fetch_count !== 16'd2 || bus.cc !== 16'd2) begin bad++; $display("FAIL basic_counts got fc=%0d cc=%0d exp 2/2", bus.fetch_count, bus.cc); end
  endtask

  task automatic test_stall();
    logic [31:0] instr0;
    logic [15:0] fc0, cc0;
    repeat (2) cycle();  // pc reaches 0x10
    total++; if (bus.pc !== 32'h10) begin bad++; $display("FAIL stall_setup got=%h exp=10", bus.pc); end
    instr0 = m_instr; fc0 = exp_fc(); cc0 = exp_cc();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (bus.pc !== 32'h10 || bus.id_instr !== instr0 || bus.fetch_count !== fc0) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%0d exp=10/%h/%0d", i, bus.pc, bus.id_instr, bus.fetch_count, instr0, fc0); end
    end
    total++; if (bus.cc !== cc0 + 16'd3) begin bad++; $display("FAIL stall_cc got=%0d exp=%0d", bus.cc, cc0 + 16'd3); end
    bus.stall = 1'b0;
  endtask

  task automatic test_redirect_stall();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40; bus.stall = 1'b1;
    cycle();
    bus.redirect = 1'b0;  // stall stays high into the FLUSH cycle
    total++; if (bus.pc !== 32'h40 || bus.id_valid !== 1'b0 || bus.state !== ST_FLUSH) begin bad++; $display("FAIL redir_edge got=%h/%b/%0d exp=40/0/FLUSH", bus.pc, bus.id_valid, bus.state); end
    cycle();
    total++; if (bus.id_instr !== rom_read(32'h40) || bus.id_valid !== 1'b1 || bus.pc !== 32'h44) begin bad++; $display("FAIL redir_target got=%h/%b/%h exp=%h/1/44", bus.id_instr, bus.id_valid, bus.pc, rom_read(32'h40)); end
    total++; if (bus.state !== ST_RUN) begin bad++; $display("FAIL redir_state got=%0d exp=RUN", bus.state); end
    bus.stall = 1'b0;
  endtask

  task automatic test_misaligned();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h42;
    cycle();
    bus.redirect = 1'b0;
    total++; if (bus.pc !== 32'h40 || bus.misaligned !== 1'b1) begin bad++; $display("FAIL misalign_set got=%h/%b exp=40/1", bus.pc, bus.misaligned); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
    cycle();
    bus.redirect = 1'b0;
    repeat (4) cycle();
    total++; if (bus.misaligned !== 1'b1) begin bad++; $display("FAIL misalign_sticky got=%b exp=1", bus.misaligned); end
  endtask

  task automatic test_halt();
    rom_mem[2] = HALT_WORD;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
    cycle();
    bus.redirect = 1'b0;
    repeat (2) cycle();  // pc now 8, halt word on imem_data
    bus.redirect = 1'b1; bus.redirect_pc = 32'h20;
    cycle();
    total++; if (bus.halted !== 1'b0 || bus.pc !== 32'h20 || bus.state !== ST_FLUSH) begin bad++; $display("FAIL halt_vs_redirect got=%b/%h/%0d exp=0/20/FLUSH", bus.halted, bus.pc, bus.state); end
    bus.redirect_pc = 32'h0;
    cycle();
    bus.redirect = 1'b0;
    repeat (3) cycle();
    total++; if (bus.id_instr !== HALT_WORD || bus.id_valid !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== 32'h8) begin bad++; $display("FAIL halt_entry got=%h/%b/%b/%h exp=fc000000/1/1/8", bus.id_instr, bus.id_valid, bus.halted, bus.pc); end
    for (int i = 0; i < 4; i++) begin
      bus.stall = 1'($urandom_range(0, 1));
      cycle();
      total++; if (bus.halted !== 1'b1 || bus.pc !== 32'h8 || bus.id_valid !== 1'b0 || bus.id_instr !== NOP_WORD || bus.fetch_count !== exp_fc()) begin bad++; $display("FAIL halt_hold[%0d] got=%b/%h/%b/%h/%0d exp=1/8/0/0/%0d", i, bus.halted, bus.pc, bus.id_valid, bus.id_instr, bus.fetch_count, exp_fc()); end
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
    cycle();
    bus.redirect = 1'b0;
    total++; if (bus.halted !== 1'b0 || bus.pc !== 32'h0) begin bad++; $display("FAIL halt_exit got=%b/%h exp=0/0", bus.halted, bus.pc); end
    cycle();
    total++; if (bus.id_instr !== rom_mem[0] || bus.id_valid !== 1'b1) begin bad++; $display("FAIL halt_resume got=%h/%b exp=%h/1", bus.id_instr, bus.id_valid, rom_mem[0]); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.redirect = ($urandom_range(0, 9) == 0);
      bus.redirect_pc = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) != 0) bus.redirect_pc[1:0] = 2'b00;
      cycle();
      total++;
      if (bus.pc !== m_pc || bus.id_valid !== m_valid || bus.id_instr !== m_instr ||
          (m_valid && bus.id_pc4 !== m_pc4) || bus.fetch_count !== exp_fc() ||
          bus.cc !== exp_cc() || bus.halted !== m_halted || bus.misaligned !== m_mis ||
          bus.state !== exp_state()) begin
        bad++;
        if (errs < 10)
          $display("FAIL random[%0d] got pc=%h v=%b i=%h p4=%h fc=%0d cc=%0d h=%b m=%b st=%0d exp pc=%h v=%b i=%h p4=%h fc=%0d cc=%0d h=%b m=%b st=%0d",
                   i, bus.pc, bus.id_valid, bus.id_instr, bus.id_pc4, bus.fetch_count, bus.cc, bus.halted, bus.misaligned, bus.state,
                   m_pc, m_valid, m_instr, m_pc4, exp_fc(), exp_cc(), m_halted, m_mis, exp_state());
        errs++;
      end
    end
    bus.stall = 1'b0; bus.redirect = 1'b0;
  endtask

  task automatic test_counters_and_async_reset();
    rom_init();  // no halt word anywhere
    do_reset();
    for (int i = 1; i <= 70000; i++) begin
      cycle();
      if (i == 65536) begin
        total++; if (bus.fetch_count !== 16'h0 || bus.cc !== 16'hFFFF) begin bad++; $display("FAIL fc_wrap got fc=%h cc=%h exp 0/ffff", bus.fetch_count, bus.cc); end
      end
    end
    total++; if (bus.cc !== 16'hFFFF) begin bad++; $display("FAIL cc_saturate got=%h exp=ffff", bus.cc); end
    total++; if (bus.fetch_count !== 16'(70000 % 65536) || bus.pc !== 32'(70000 * 4)) begin bad++; $display("FAIL long_run got fc=%0d pc=%h exp fc=%0d pc=%h", bus.fetch_count, bus.pc, 70000 % 65536, 70000 * 4); end
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    total++; if (bus.pc !== RESET_PC || bus.cc !== 16'h0 || bus.fetch_count !== 16'h0 || bus.id_valid !== 1'b0 || bus.id_instr !== NOP_WORD || bus.id_pc4 !== 32'h0 || bus.halted !== 1'b0 || bus.misaligned !== 1'b0) begin bad++; $display("FAIL async_reset got pc=%h cc=%h fc=%h v=%b i=%h p4=%h h=%b m=%b exp all reset", bus.pc, bus.cc, bus.fetch_count, bus.id_valid, bus.id_instr, bus.id_pc4, bus.halted, bus.misaligned); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    rom_init();
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_halt();
    test_random();
    test_counters_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the instruction ROM address, and loads the IF/ID pipeline register. Stall requests come from the load-use bubbler and redirects (jump / taken branch) from EX. Also provides the cycle counter and fetch statistics that the UI handler displays.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_WORD, 32'hFC00_0000: instruction word (opcode 6'h3F) that halts fetch.
- NOP_WORD, 32'h0000_0000: word placed in IF/ID on flush or bubble.
- clock  in  1  pipeline clock (manual or divided system clock).
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC and IF/ID (load-use bubble).
- redirect  in  1  EX resolved a jump or taken branch.
- redirect_pc  in  32  target address; bits [1:0] ignored.
- imem_addr  out  32  ROM byte address; equals pc.
- imem_data  in  32  ROM word for imem_addr; valid before the next rising edge (ROM reads on the falling edge).
- id_instr  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID address of that instruction plus 4 (used for the JAL link).
- id_valid  out  1  IF/ID holds a real instruction.
- pc  out  32  current fetch address.
- cc  out  16  cycles since reset, saturating.
- fetch_count  out  16  instructions loaded into IF/ID, wrapping.
- halted  out  1  fetch FSM is in HALT.
- misaligned  out  1  sticky: a redirect_pc had bits [1:0] != 0.

## Operation
- FSM states are RUN, FLUSH and HALT. Reset enters RUN.
- Priority on each rising edge: reset, then redirect, then stall, then normal fetch.
- redirect (any state):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID <= NOP_WORD with id_valid=0.
  - Next state is FLUSH.
  - If redirect_pc[1:0] != 0, set misaligned.
- FLUSH: one cycle. Behaves as RUN (fetches at the new pc), then goes to RUN. It exists so that a stall arriving in the same cycle is ignored: stale bubbler data must not hold the redirected fetch.
- RUN with stall=1: pc, IF/ID and fetch_count hold.
- RUN with stall=0, normal fetch:
  - pc <= pc+4.
  - id_instr <= imem_data, id_pc4 <= pc+4, id_valid <= 1.
  - fetch_count increments.
- HALT entry: in RUN/FLUSH, if stall=0 and imem_data == HALT_WORD:
  - The halt word is loaded into IF/ID as normal.
  - pc does not advance.
  - Next state is HALT.
- In HALT:
  - pc holds.
  - IF/ID <= NOP_WORD with id_valid=0 every cycle.
  - fetch_count holds.
  - Only redirect or reset leaves HALT.
- cc increments every cycle and saturates at 16'hFFFF. It counts regardless of state.
- pc+4 wraps modulo 2^32 and raises no flag.

## Timing
- Reset values:
  - pc=RESET_PC, imem_addr=RESET_PC.
  - id_instr=NOP_WORD, id_pc4=0, id_valid=0.
  - cc=0, fetch_count=0.
  - halted=0, misaligned=0.
- imem_addr is combinational from the pc register, with zero added latency.
- Fetch-to-IF/ID latency is 1 edge: the word addressed in cycle n appears on id_instr after edge n+1.
- Redirect penalty: the IF/ID contents become a bubble on the redirect edge. The first target instruction is valid one edge later.
- Simultaneous redirect and stall: redirect wins and the stall is dropped.
- Simultaneous redirect and the halt word on imem_data: redirect wins and HALT is not entered.
- Reset mid-stall or mid-HALT: all state returns to reset values asynchronously.

## Structure
- A shared pipeline package holds HALT_WORD, NOP_WORD and the fetch FSM state encoding. The package is shared with the controller, which decodes opcode 6'h3F as halt.
- One natural sub-module is sat_counter (width parameter, saturate/wrap select), instanced twice: once for cc and once for fetch_count.

## Test plan
- Reset, ROM holds 0x20080001 at address 0 and 0x20090002 at address 4, stall=0 → after edge 1: id_instr=0x20080001, id_pc4=4, pc=8 after edge 2; fetch_count=2.
- stall=1 for 3 cycles mid-run at pc=0x10 → pc, id_instr and fetch_count unchanged for 3 edges; cc advances by 3.
- redirect=1 with redirect_pc=0x40 and stall=1 on the same edge → pc=0x40, id_valid=0, state FLUSH; next edge id_instr=ROM[0x40], id_valid=1.
- redirect_pc=0x42 → pc=0x40, misaligned=1 and stays 1 until reset.
- ROM[0x8]=0xFC000000 → IF/ID gets 0xFC000000, then halted=1, pc=0x8 held, id_valid=0; redirect to 0x0 clears halted and fetch resumes.
- Run 70000 cycles → cc=16'hFFFF (saturated); fetch_count wraps past 16'hFFFF to 0; assert reset mid-run → all outputs at their reset values without a clock edge.
